// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game engine: consumes key events, keeps the board, alternates turns,
// rejects occupied-cell presses and reports win / draw with the winning line mask.
module ttt_game_ctrl #(
    parameter bit         FIRST_O   = 1'b0,
    parameter logic [3:0] START_KEY = 4'd1,
    parameter logic [3:0] KEY_STAR  = 4'd10,
    parameter logic [3:0] KEY_HASH  = 4'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        is_main,
    output logic [17:0] board,
    output logic        turn_o,
    output logic [3:0]  move_cnt,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [7:0]  win_line,
    output logic        illegal
);

    typedef enum logic [1:0] {MAIN, PLAY, CHECK, DONE} state_e;

    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  winLine_q, winLine_d;
    logic        illegal_q, illegal_d;
    logic        isMain_q, isMain_d;
    logic        gameOver_q, gameOver_d;

    logic [8:0]  cellHit;
    logic        cellPress, cellBusy;
    logic        startPress, starPress, hashPress;
    logic [1:0]  moverCode;
    logic [7:0]  winMask;
    logic        clearGame, goMain;

    // Cells are numbered 1..9; cell n lives at bits [2n-1:2n-2].
    function automatic logic lineWon(input logic [17:0] b, input int a, input int c,
                                     input int d, input logic [1:0] m);
        return (b[2*a-2 +: 2] == m) && (b[2*c-2 +: 2] == m) && (b[2*d-2 +: 2] == m);
    endfunction

    assign startPress = key_valid && (key_code == START_KEY);
    assign starPress  = key_valid && (key_code == KEY_STAR);
    assign hashPress  = key_valid && (key_code == KEY_HASH);
    assign moverCode  = turn_q ? 2'b10 : 2'b01;

    always_comb begin
        cellHit  = '0;
        cellBusy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cellHit[i] = key_valid && (key_code == 4'(i + 1));
            if (cellHit[i] && (board_q[2*i +: 2] != 2'b00)) cellBusy = 1'b1;
        end
        cellPress = |cellHit;
    end

    // Only the player who just moved can have completed a line.
    always_comb begin
        winMask[0] = lineWon(board_q, 1, 2, 3, moverCode);
        winMask[1] = lineWon(board_q, 4, 5, 6, moverCode);
        winMask[2] = lineWon(board_q, 7, 8, 9, moverCode);
        winMask[3] = lineWon(board_q, 1, 4, 7, moverCode);
        winMask[4] = lineWon(board_q, 2, 5, 8, moverCode);
        winMask[5] = lineWon(board_q, 3, 6, 9, moverCode);
        winMask[6] = lineWon(board_q, 1, 5, 9, moverCode);
        winMask[7] = lineWon(board_q, 3, 5, 7, moverCode);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MAIN;
            board_q    <= '0;
            turn_q     <= FIRST_O;
            cnt_q      <= '0;
            winner_q   <= '0;
            winLine_q  <= '0;
            illegal_q  <= 1'b0;
            isMain_q   <= 1'b1;
            gameOver_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            cnt_q      <= cnt_d;
            winner_q   <= winner_d;
            winLine_q  <= winLine_d;
            illegal_q  <= illegal_d;
            isMain_q   <= isMain_d;
            gameOver_q <= gameOver_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN:  if (startPress) state_d = PLAY;
            PLAY: begin
                if (starPress) state_d = MAIN;
                else if (cellPress && !cellBusy) state_d = CHECK;
            end
            CHECK: begin
                if (starPress) state_d = MAIN;
                else if ((|winMask) || (cnt_q == 4'd9)) state_d = DONE;
                else state_d = PLAY;
            end
            DONE: begin
                if (starPress) state_d = MAIN;
                else if (hashPress) state_d = PLAY;
            end
            default: state_d = MAIN;
        endcase
    end

    always_comb begin
        board_d    = board_q;
        turn_d     = turn_q;
        cnt_d      = cnt_q;
        winner_d   = winner_q;
        winLine_d  = winLine_q;
        illegal_d  = 1'b0;
        isMain_d   = isMain_q;
        gameOver_d = gameOver_q;
        clearGame  = 1'b0;
        goMain     = 1'b0;
        case (state_q)
            MAIN: clearGame = startPress;
            PLAY: begin
                if (starPress) begin
                    goMain = 1'b1;
                end else if (cellPress && cellBusy) begin
                    illegal_d = 1'b1;
                end else if (cellPress) begin
                    for (int i = 0; i < 9; i++)
                        if (cellHit[i]) board_d[2*i +: 2] = moverCode;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                if (starPress) begin
                    goMain = 1'b1;
                end else if (|winMask) begin
                    gameOver_d = 1'b1;
                    winner_d   = moverCode;
                    winLine_d  = winMask;
                end else if (cnt_q == 4'd9) begin
                    gameOver_d = 1'b1;
                    winner_d   = 2'b11;
                    winLine_d  = '0;
                end else begin
                    turn_d = ~turn_q;
                end
            end
            DONE: begin
                if (starPress) goMain = 1'b1;
                else clearGame = hashPress;
            end
            default: goMain = 1'b1;
        endcase
        if (clearGame || goMain) begin
            board_d    = '0;
            turn_d     = FIRST_O;
            cnt_d      = '0;
            winner_d   = '0;
            winLine_d  = '0;
            gameOver_d = 1'b0;
            isMain_d   = goMain;
        end
    end

    assign is_main   = isMain_q;
    assign board     = board_q;
    assign turn_o    = turn_q;
    assign move_cnt  = cnt_q;
    assign game_over = gameOver_q;
    assign winner    = winner_q;
    assign win_line  = winLine_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl: start/abort, moves, illegal
// presses, row win, draw, ninth-move win, dropped key in CHECK and async reset.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        is_main;
    logic [17:0] board;
    logic        turn_o;
    logic [3:0]  move_cnt;
    logic        game_over;
    logic [1:0]  winner;
    logic [7:0]  win_line;
    logic        illegal;

    int compared = 0;
    int mismatched = 0;

    ttt_game_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .is_main(is_main), .board(board), .turn_o(turn_o), .move_cnt(move_cnt),
        .game_over(game_over), .winner(winner), .win_line(win_line), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // One-cycle key pulse; returns on the negedge right after the capturing posedge.
    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        repeat (2) @(negedge clk);
        compared++; if (is_main !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_is_main: got %0h expected 1", is_main); end
        compared++; if (board !== 18'h0) begin mismatched++; $display("[TB] FAIL reset_board: got %h expected 0", board); end
        compared++; if (turn_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_turn: got %0h expected 0", turn_o); end
        compared++; if (move_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_cnt: got %0d expected 0", move_cnt); end
        compared++; if (game_over !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_game_over: got %0h expected 0", game_over); end
        compared++; if (winner !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_winner: got %b expected 00", winner); end
        compared++; if (win_line !== 8'h0) begin mismatched++; $display("[TB] FAIL reset_win_line: got %b expected 0", win_line); end
        compared++; if (illegal !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_illegal: got %0h expected 0", illegal); end
        rst = 1'b0;
        @(negedge clk);
        compared++; if (is_main !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_is_main: got %0h expected 1", is_main); end
    endtask

    task automatic test_first_move();
        applyStimulus(4'd1);
        compared++; if (is_main !== 1'b0) begin mismatched++; $display("[TB] FAIL start_is_main: got %0h expected 0", is_main); end
        compared++; if (board !== 18'h0) begin mismatched++; $display("[TB] FAIL start_board: got %h expected 0", board); end
        compared++; if (turn_o !== 1'b0) begin mismatched++; $display("[TB] FAIL start_turn: got %0h expected 0", turn_o); end
        applyStimulus(4'd5);
        compared++; if (board !== 18'h00100) begin mismatched++; $display("[TB] FAIL move5_board: got %h expected 00100", board); end
        compared++; if (move_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL move5_cnt: got %0d expected 1", move_cnt); end
        compared++; if (turn_o !== 1'b0) begin mismatched++; $display("[TB] FAIL move5_turn_t1: got %0h expected 0", turn_o); end
        @(negedge clk);
        compared++; if (turn_o !== 1'b1) begin mismatched++; $display("[TB] FAIL move5_turn_t2: got %0h expected 1", turn_o); end
        compared++; if (game_over !== 1'b0) begin mismatched++; $display("[TB] FAIL move5_game_over: got %0h expected 0", game_over); end
    endtask

    task automatic test_abort();
        applyStimulus(4'd10);
        compared++; if (is_main !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_is_main: got %0h expected 1", is_main); end
        compared++; if (board !== 18'h0) begin mismatched++; $display("[TB] FAIL abort_board: got %h expected 0", board); end
        compared++; if (move_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL abort_cnt: got %0d expected 0", move_cnt); end
        applyStimulus(4'd7);
        compared++; if (is_main !== 1'b1) begin mismatched++; $display("[TB] FAIL main_key7_is_main: got %0h expected 1", is_main); end
        compared++; if (board !== 18'h0) begin mismatched++; $display("[TB] FAIL main_key7_board: got %h expected 0", board); end
        applyStimulus(4'd1);
        compared++; if (is_main !== 1'b0) begin mismatched++; $display("[TB] FAIL restart_is_main: got %0h expected 0", is_main); end
        compared++; if (turn_o !== 1'b0) begin mismatched++; $display("[TB] FAIL restart_turn: got %0h expected 0", turn_o); end
    endtask

    task automatic test_row_win();
        logic [3:0] seq [5] = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3};
        foreach (seq[i]) applyStimulus(seq[i]);
        @(negedge clk);
        compared++; if (game_over !== 1'b1) begin mismatched++; $display("[TB] FAIL row_game_over: got %0h expected 1", game_over); end
        compared++; if (winner !== 2'b01) begin mismatched++; $display("[TB] FAIL row_winner: got %b expected 01", winner); end
        compared++; if (win_line !== 8'b00000001) begin mismatched++; $display("[TB] FAIL row_win_line: got %b expected 00000001", win_line); end
        compared++; if (move_cnt !== 4'd5) begin mismatched++; $display("[TB] FAIL row_cnt: got %0d expected 5", move_cnt); end
        compared++; if (board !== 18'h00295) begin mismatched++; $display("[TB] FAIL row_board: got %h expected 00295", board); end
        applyStimulus(4'd9);
        compared++; if (board !== 18'h00295) begin mismatched++; $display("[TB] FAIL done_key9_board: got %h expected 00295", board); end
        compared++; if (illegal !== 1'b0) begin mismatched++; $display("[TB] FAIL done_key9_illegal: got %0h expected 0", illegal); end
        compared++; if (move_cnt !== 4'd5) begin mismatched++; $display("[TB] FAIL done_key9_cnt: got %0d expected 5", move_cnt); end
    endtask

    task automatic test_illegal();
        applyStimulus(4'd11);
        compared++; if (game_over !== 1'b0) begin mismatched++; $display("[TB] FAIL hash_game_over: got %0h expected 0", game_over); end
        compared++; if (board !== 18'h0) begin mismatched++; $display("[TB] FAIL hash_board: got %h expected 0", board); end
        applyStimulus(4'd5);
        applyStimulus(4'd5);
        compared++; if (illegal !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_pulse: got %0h expected 1", illegal); end
        compared++; if (board !== 18'h00100) begin mismatched++; $display("[TB] FAIL illegal_board: got %h expected 00100", board); end
        compared++; if (move_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL illegal_cnt: got %0d expected 1", move_cnt); end
        compared++; if (turn_o !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_turn: got %0h expected 1", turn_o); end
        @(negedge clk);
        compared++; if (illegal !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_one_cycle: got %0h expected 0", illegal); end
        compared++; if (turn_o !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_turn_hold: got %0h expected 1", turn_o); end
    endtask

    task automatic test_draw();
        logic [3:0] seq [9] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd7, 4'd9};
        applyStimulus(4'd10);
        applyStimulus(4'd1);
        foreach (seq[i]) applyStimulus(seq[i]);
        @(negedge clk);
        compared++; if (board !== 18'h16A59) begin mismatched++; $display("[TB] FAIL draw_board: got %h expected 16a59", board); end
        compared++; if (winner !== 2'b11) begin mismatched++; $display("[TB] FAIL draw_winner: got %b expected 11", winner); end
        compared++; if (win_line !== 8'h0) begin mismatched++; $display("[TB] FAIL draw_win_line: got %b expected 0", win_line); end
        compared++; if (move_cnt !== 4'd9) begin mismatched++; $display("[TB] FAIL draw_cnt: got %0d expected 9", move_cnt); end
        compared++; if (game_over !== 1'b1) begin mismatched++; $display("[TB] FAIL draw_game_over: got %0h expected 1", game_over); end
        applyStimulus(4'd11);
        compared++; if (board !== 18'h0) begin mismatched++; $display("[TB] FAIL newgame_board: got %h expected 0", board); end
        compared++; if (game_over !== 1'b0) begin mismatched++; $display("[TB] FAIL newgame_game_over: got %0h expected 0", game_over); end
        compared++; if (turn_o !== 1'b0) begin mismatched++; $display("[TB] FAIL newgame_turn: got %0h expected 0", turn_o); end
        compared++; if (move_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL newgame_cnt: got %0d expected 0", move_cnt); end
        compared++; if (winner !== 2'b00) begin mismatched++; $display("[TB] FAIL newgame_winner: got %b expected 00", winner); end
    endtask

    task automatic test_ninth_move_win();
        logic [3:0] seq [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd7, 4'd9};
        foreach (seq[i]) applyStimulus(seq[i]);
        @(negedge clk);
        compared++; if (winner !== 2'b01) begin mismatched++; $display("[TB] FAIL ninth_winner: got %b expected 01", winner); end
        compared++; if (win_line !== 8'h40) begin mismatched++; $display("[TB] FAIL ninth_win_line: got %b expected 01000000", win_line); end
        compared++; if (move_cnt !== 4'd9) begin mismatched++; $display("[TB] FAIL ninth_cnt: got %0d expected 9", move_cnt); end
        compared++; if (game_over !== 1'b1) begin mismatched++; $display("[TB] FAIL ninth_game_over: got %0h expected 1", game_over); end
        applyStimulus(4'd11);
    endtask

    task automatic test_dropped_key();
        @(negedge clk);
        key_valid = 1'b1; key_code = 4'd5;
        @(negedge clk);
        key_code = 4'd9;
        @(negedge clk);
        key_valid = 1'b0; key_code = 4'd0;
        compared++; if (board !== 18'h00100) begin mismatched++; $display("[TB] FAIL drop_board: got %h expected 00100", board); end
        compared++; if (move_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL drop_cnt: got %0d expected 1", move_cnt); end
        compared++; if (turn_o !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_turn: got %0h expected 1", turn_o); end
        @(negedge clk);
        compared++; if (board !== 18'h00100) begin mismatched++; $display("[TB] FAIL drop_board_later: got %h expected 00100", board); end
    endtask

    task automatic test_reset_in_check();
        applyStimulus(4'd1);
        compared++; if (board !== 18'h00102) begin mismatched++; $display("[TB] FAIL precheck_board: got %h expected 00102", board); end
        #2 rst = 1'b1;
        #1;
        compared++; if (is_main !== 1'b1) begin mismatched++; $display("[TB] FAIL async_is_main: got %0h expected 1", is_main); end
        compared++; if (board !== 18'h0) begin mismatched++; $display("[TB] FAIL async_board: got %h expected 0", board); end
        compared++; if (turn_o !== 1'b0) begin mismatched++; $display("[TB] FAIL async_turn: got %0h expected 0", turn_o); end
        compared++; if (move_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL async_cnt: got %0d expected 0", move_cnt); end
        compared++; if (game_over !== 1'b0) begin mismatched++; $display("[TB] FAIL async_game_over: got %0h expected 0", game_over); end
        compared++; if (winner !== 2'b00) begin mismatched++; $display("[TB] FAIL async_winner: got %b expected 00", winner); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (is_main !== 1'b1) begin mismatched++; $display("[TB] FAIL after_rst_is_main: got %0h expected 1", is_main); end
        compared++; if (turn_o !== 1'b0) begin mismatched++; $display("[TB] FAIL after_rst_turn: got %0h expected 0", turn_o); end
        compared++; if (board !== 18'h0) begin mismatched++; $display("[TB] FAIL after_rst_board: got %h expected 0", board); end
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_abort();
        test_row_win();
        test_illegal();
        test_draw();
        test_ninth_move_win();
        test_dropped_key();
        test_reset_in_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Game engine for the tic-tac-toe board.
- Sits directly downstream of the keypad scanner / main-screen block.
- Consumes one-cycle key events, keeps the 9-cell board, alternates turns, rejects illegal moves, and detects win and draw.
- Its registered outputs (board, turn, result, winning line) feed the dot-matrix renderer and the 7-segment status display.

Parameters:
- FIRST_O, 0, player who moves first after a new game: 0 = X, 1 = O.
- START_KEY, 1, key code that leaves the main screen and starts a game.
- KEY_STAR, 10, key code for '*' (abort to main screen).
- KEY_HASH, 11, key code for '#' (new game after result).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- key_valid, input, 1, one-cycle pulse; key_code is valid in that cycle.
- key_code, input, 4, 1..9 = board cell (row-major, 1 top-left), 10 = '*', 11 = '#', other values ignored.
- is_main, output, 1, 1 while in the main (attract) screen.
- board, output, 18, cell n (1..9) at bits [2n-1:2n-2]; 00 = empty, 01 = X, 10 = O.
- turn_o, output, 1, 1 = O to move, 0 = X to move.
- move_cnt, output, 4, number of filled cells, 0..9.
- game_over, output, 1, 1 in DONE.
- winner, output, 2, 00 = none, 01 = X, 10 = O, 11 = draw; valid when game_over = 1.
- win_line, output, 8, one-hot line mask. Bit 0..2 = rows, 3..5 = columns, 6 = main diagonal (1,5,9), 7 = anti-diagonal (3,5,7). More than one bit may be set when a move completes two lines.
- illegal, output, 1, one-cycle pulse on a rejected cell press during PLAY.

Behaviour:
- Async reset: state = MAIN, is_main = 1, board = 0, turn_o = FIRST_O, move_cnt = 0, game_over = 0, winner = 00, win_line = 0, illegal = 0. All outputs are registered.
- States: MAIN, PLAY, CHECK, DONE.
- MAIN:
  - key_valid with key_code == START_KEY → PLAY.
  - On that transition: clear board, move_cnt, winner and win_line; set turn_o = FIRST_O; is_main = 0.
  - All other keys are ignored.
- PLAY, key_valid with code 1..9:
  - Cell empty: write 01 if turn_o = 0, else 10. Increment move_cnt. Go to CHECK. Board is visible the next cycle.
  - Cell occupied: illegal = 1 for exactly one cycle; board, turn and state are unchanged.
- CHECK (exactly one cycle; key_valid is ignored here):
  - Evaluate all 8 lines for three equal non-empty cells belonging to the mover.
  - Any line won → DONE; winner = mover's code; win_line = mask of all winning lines.
  - Else if move_cnt == 9 → DONE; winner = 11; win_line = 0.
  - Else toggle turn_o → PLAY.
- Latency: key press at cycle t → board updated at t+1 → winner/turn_o updated at t+2. A key_valid arriving at t+1 is dropped.
- DONE:
  - game_over = 1. Board is frozen; cell keys are ignored (no illegal pulse).
  - KEY_HASH → PLAY with board cleared, move_cnt = 0, game_over = 0, winner = 00, win_line = 0, turn_o = FIRST_O.
- '*' (KEY_STAR) in PLAY, CHECK or DONE → MAIN; board cleared, all result outputs cleared, is_main = 1. '*' takes priority over the CHECK evaluation in that cycle.
- Key codes 0, 12..15, and KEY_HASH outside DONE are ignored in every state.
- Reset asserted mid-game or mid-CHECK forces the reset values immediately. No move completes after reset release.
- move_cnt never exceeds 9. A win on the 9th move reports the winner, not a draw.

Test Plan:
- Reset, then key 1 → is_main = 0, board = 0, turn_o = 0. Key 5 → board = 18'h00100 (cell 5 = 01) at t+1; turn_o = 1 at t+2.
- X plays 1, 2, 3 and O plays 4, 5 (order 1, 4, 2, 5, 3) → after key 3: game_over = 1, winner = 01, win_line = 8'b00000001, move_cnt = 5. A further key 9 leaves board unchanged.
- Press 5 twice in PLAY → second press: illegal high for 1 cycle; board, turn_o and move_cnt unchanged.
- Draw sequence 1, 2, 3, 5, 4, 6, 8, 7, 9 → winner = 11, win_line = 0, move_cnt = 9. Then '#' → board = 0, game_over = 0, turn_o = 0.
- Mid-game '*' → is_main = 1, board = 0. Key 7 while in MAIN → ignored. Key 1 → PLAY.
- Assert rst asynchronously in the cycle after a cell press (CHECK) → all outputs return to reset values without waiting for a clock edge. A key_valid pulse at t+1 is confirmed dropped.
